// File: rtl/som_seq_if.sv
// som_seq_if: start/stall handshake and RAM port bundle for som_seq_controller
//  ports: start, stall (to controller); busy, done, W_update_latch (status);
//         RAM_IF_A/OE (image read), RAM_W_A/WE (weight write), RAM_RESULT_A/WE (result write);
//         epoch_idx only when SOM_MULTI_EPOCH_EN is defined
//  modports: master = controller side, slave = system side
interface som_seq_if #(
  parameter int ADDR_W  = 18,
  parameter int EPOCH_W = 2
);
  logic              start, stall, busy, done, W_update_latch;
  logic [ADDR_W-1:0] RAM_IF_A, RAM_W_A, RAM_RESULT_A;
  logic              RAM_IF_OE, RAM_W_WE, RAM_RESULT_WE;
`ifdef SOM_MULTI_EPOCH_EN
  logic [EPOCH_W-1:0] epoch_idx;
  modport master (
    input  start, stall,
    output busy, done, W_update_latch, RAM_IF_A, RAM_IF_OE,
           RAM_W_A, RAM_W_WE, RAM_RESULT_A, RAM_RESULT_WE, epoch_idx
  );
  modport slave (
    output start, stall,
    input  busy, done, W_update_latch, RAM_IF_A, RAM_IF_OE,
           RAM_W_A, RAM_W_WE, RAM_RESULT_A, RAM_RESULT_WE, epoch_idx
  );
`else
  modport master (
    input  start, stall,
    output busy, done, W_update_latch, RAM_IF_A, RAM_IF_OE,
           RAM_W_A, RAM_W_WE, RAM_RESULT_A, RAM_RESULT_WE
  );
  modport slave (
    output start, stall,
    input  busy, done, W_update_latch, RAM_IF_A, RAM_IF_OE,
           RAM_W_A, RAM_W_WE, RAM_RESULT_A, RAM_RESULT_WE
  );
`endif
endinterface

// File: rtl/som_seq_controller.sv
// som_seq_controller: frame sequencer TRAIN -> write weights -> MAP -> done for the SOM system
//  ports: clk, rst (async active-high), bus (som_seq_if.master: start/stall in, status and RAM ports out)
//  SOM_MULTI_EPOCH_EN: TRAIN repeats NUM_EPOCH passes and drives bus.epoch_idx
module som_seq_controller #(
  parameter int ADDR_W    = 18,
  parameter int IMG_PIX   = 4096,
  parameter int NUM_W     = 64,
  parameter int NUM_IMG   = 1,
  parameter int NUM_EPOCH = 4
) (
  input logic       clk,
  input logic       rst,
  som_seq_if.master bus
);
  localparam int TOTAL = NUM_IMG * IMG_PIX;
  localparam int CW    = ADDR_W + 1;
  typedef enum logic [2:0] {IDLE, TRAIN, TDRAIN, WR_W, MAP, MDRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] if_a_q, if_a_d, w_a_q, w_a_d, res_a_q, res_a_d;
  logic              oe_q, oe_d, we_q, we_d, res_we_q, res_we_d, upd_q, upd_d;
  logic              busy_q, busy_d, done_q, done_d, idle;
`ifdef SOM_MULTI_EPOCH_EN
  localparam int EW = NUM_EPOCH > 1 ? $clog2(NUM_EPOCH) : 1;
  logic [EW-1:0] ep_q, ep_d;
  assign bus.epoch_idx = ep_q;
`endif
  assign idle = state_q == IDLE || state_q == DONE;
  // cnt_q is the next address to issue in the current phase; outputs show the one issued now
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    if_a_d   = if_a_q;
    w_a_d    = w_a_q;
    oe_d     = 1'b0;
    we_d     = 1'b0;
    upd_d    = oe_q && state_q == TRAIN;
    res_we_d = oe_q && state_q == MAP;
    res_a_d  = res_we_d ? if_a_q : res_a_q;
`ifdef SOM_MULTI_EPOCH_EN
    ep_d     = ep_q;
`endif
    if (idle && bus.start) begin
      state_d = TRAIN;
      oe_d    = !bus.stall;
      cnt_d   = bus.stall ? '0 : CW'(1);
      if_a_d  = '0;
      w_a_d   = '0;
      res_a_d = '0;
`ifdef SOM_MULTI_EPOCH_EN
      ep_d    = '0;
`endif
    end else if (!idle && !bus.stall) begin
      case (state_q)
        TRAIN:
          if (cnt_q != CW'(TOTAL)) begin
            oe_d   = 1'b1;
            if_a_d = cnt_q[ADDR_W-1:0];
            cnt_d  = cnt_q + CW'(1);
          end
`ifdef SOM_MULTI_EPOCH_EN
          else if (ep_q != EW'(NUM_EPOCH - 1)) begin
            ep_d   = ep_q + EW'(1);
            oe_d   = 1'b1;
            if_a_d = '0;
            cnt_d  = CW'(1);
          end
`endif
          else state_d = TDRAIN;
        TDRAIN: begin
          state_d = WR_W;
          we_d    = 1'b1;
          w_a_d   = '0;
          cnt_d   = CW'(1);
        end
        WR_W:
          if (cnt_q != CW'(NUM_W)) begin
            we_d  = 1'b1;
            w_a_d = cnt_q[ADDR_W-1:0];
            cnt_d = cnt_q + CW'(1);
          end else begin
            state_d = MAP;
            oe_d    = 1'b1;
            if_a_d  = '0;
            cnt_d   = CW'(1);
          end
        MAP:
          if (cnt_q != CW'(TOTAL)) begin
            oe_d   = 1'b1;
            if_a_d = cnt_q[ADDR_W-1:0];
            cnt_d  = cnt_q + CW'(1);
          end else state_d = MDRAIN;
        MDRAIN: state_d = DONE;
        default: state_d = state_q;
      endcase
    end
    busy_d = state_d != IDLE && state_d != DONE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      if_a_q   <= '0;
      w_a_q    <= '0;
      res_a_q  <= '0;
      oe_q     <= 1'b0;
      we_q     <= 1'b0;
      res_we_q <= 1'b0;
      upd_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SOM_MULTI_EPOCH_EN
      ep_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      if_a_q   <= if_a_d;
      w_a_q    <= w_a_d;
      res_a_q  <= res_a_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      res_we_q <= res_we_d;
      upd_q    <= upd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SOM_MULTI_EPOCH_EN
      ep_q     <= ep_d;
`endif
    end
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.W_update_latch = upd_q;
  assign bus.RAM_IF_A       = if_a_q;
  assign bus.RAM_IF_OE      = oe_q;
  assign bus.RAM_W_A        = w_a_q;
  assign bus.RAM_W_WE       = we_q;
  assign bus.RAM_RESULT_A   = res_a_q;
  assign bus.RAM_RESULT_WE  = res_we_q;
endmodule

// File: tb/tb_som_seq_controller.sv
// tb_som_seq_controller: random and directed checks of som_seq_controller against a frame-step model
module tb_som_seq_controller;
  localparam int ADDR_W = 8, IMG_PIX = 16, NUM_W = 4, NUM_IMG = 2, NUM_EPOCH = 2;
  localparam int EW = 1;
`ifdef SOM_MULTI_EPOCH_EN
  localparam int EP = NUM_EPOCH, DONE_CYC = 103;
`else
  localparam int EP = 1, DONE_CYC = 71;
`endif
  localparam int T = NUM_IMG * IMG_PIX;
  localparam int R = T * EP, MS = R + NUM_W + 1, MD = MS + T, DK = MD + 1;
  logic clk = 0, rst = 0;
  bit go = 0;
  int checks = 0, errors = 0;
  som_seq_if #(.ADDR_W(ADDR_W), .EPOCH_W(EW)) bus();
  som_seq_controller #(.ADDR_W(ADDR_W), .IMG_PIX(IMG_PIX), .NUM_W(NUM_W), .NUM_IMG(NUM_IMG),
    .NUM_EPOCH(NUM_EPOCH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  // Model: a frame is a list of steps; step k<R train read k%T, k==R drain, then NUM_W writes,
  // then T map reads, one map drain, then done. Each unstalled edge moves one step forward.
  int k = 0;
  bit act = 0, iss = 0, e_upd = 0, e_rwe = 0;
  int e_ra = 0;
  logic take;
  assign take = bus.start && (!act || k >= DK);
  function automatic bit m_oe();
    return act && iss && k >= 0 && (k < R || (k >= MS && k < MD));
  endfunction
  function automatic bit m_we();
    return act && iss && k > R && k <= R + NUM_W;
  endfunction
  function automatic int m_if_a();
    if (!act || k < 0) return 0;
    if (k < R) return k % T;
    if (k >= MS && k < MD) return k - MS;
    return T - 1;
  endfunction
  function automatic int m_w_a();
    if (!act || k <= R) return 0;
    return k <= R + NUM_W ? k - R - 1 : NUM_W - 1;
  endfunction
  function automatic int m_ep();
    if (!act || k < 0) return 0;
    return k < R ? k / T : EP - 1;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      act <= 0; k <= 0; iss <= 0; e_upd <= 0; e_rwe <= 0; e_ra <= 0;
    end else begin
      e_upd <= m_oe() && k < R;
      e_rwe <= m_oe() && k >= MS;
      e_ra  <= (m_oe() && k >= MS) ? m_if_a() : (take ? 0 : e_ra);
      if (take) begin
        act <= 1; k <= bus.stall ? -1 : 0; iss <= !bus.stall;
      end else if (act && k < DK) begin
        k <= bus.stall ? k : k + 1; iss <= !bus.stall;
      end
    end
  always @(negedge clk)
    if (go) begin
      chk("busy", bus.busy, act && k < DK);
      chk("done", bus.done, act && k >= DK);
      chk("if_oe", bus.RAM_IF_OE, m_oe());
      chk("if_a", bus.RAM_IF_A, m_if_a());
      chk("w_we", bus.RAM_W_WE, m_we());
      chk("w_a", bus.RAM_W_A, m_w_a());
      chk("w_upd", bus.W_update_latch, e_upd);
      chk("res_we", bus.RAM_RESULT_WE, e_rwe);
      chk("res_a", bus.RAM_RESULT_A, e_ra);
`ifdef SOM_MULTI_EPOCH_EN
      chk("epoch", bus.epoch_idx, m_ep());
`endif
    end
  task automatic frame(input int stall_a, input bit start_map, output int dc, output int rd,
                       output int up, output int wr, output int rs);
    int sl = 0;
    bit stalled = 0;
    dc = 0; rd = 0; up = 0; wr = 0; rs = 0;
    @(negedge clk); bus.start = 1;
    @(negedge clk); bus.start = 0;
    for (int c = 1; c < 400 && dc == 0; c++) begin
      if (bus.done) dc = c;
      rd += int'(bus.RAM_IF_OE && c < MS);
      up += int'(bus.W_update_latch);
      wr += int'(bus.RAM_W_WE);
      rs += int'(bus.RAM_RESULT_WE);
      bus.stall = sl > 0;
      if (sl > 0) sl--;
      if (!stalled && bus.RAM_IF_OE && int'(bus.RAM_IF_A) == stall_a) begin
        stalled = 1; bus.stall = 1; sl = 2;
      end
      bus.start = start_map && c == MS + 5;
      if (dc == 0) @(negedge clk);
    end
    bus.start = 0; bus.stall = 0;
  endtask
  initial begin
    int dc, rd, up, wr, rs, n;
    bus.start = 0; bus.stall = 0;
    #1 rst = 1;
    #20 @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_oe", bus.RAM_IF_OE, 0);
    rst = 0; go = 1;
    frame(-1, 0, dc, rd, up, wr, rs);
    chk("basic_done_cycle", dc, DONE_CYC);
    chk("basic_reads", rd, T * EP);
    chk("basic_updates", up, T * EP);
    chk("basic_w_writes", wr, NUM_W);
    chk("basic_results", rs, T);
    frame(10, 0, dc, rd, up, wr, rs);
    chk("stall_done_cycle", dc, DONE_CYC + 3);
    chk("stall_reads", rd, T * EP);
    frame(-1, 1, dc, rd, up, wr, rs);
    chk("map_start_done_cycle", dc, DONE_CYC);
    @(negedge clk); bus.start = 1;
    @(negedge clk); bus.start = 0;
    chk("restart_done", bus.done, 0);
    chk("restart_oe", bus.RAM_IF_OE, 1);
    chk("restart_a", bus.RAM_IF_A, 0);
    n = 0;
    while (!(bus.RAM_W_WE && bus.RAM_W_A == 2) && n < 400) begin @(negedge clk); n++; end
    chk("reach_w_a2", n < 400, 1);
    #2 rst = 1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_we", bus.RAM_W_WE, 0);
    chk("abort_w_a", bus.RAM_W_A, 0);
    chk("abort_if_a", bus.RAM_IF_A, 0);
    chk("abort_upd", bus.W_update_latch, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    chk("post_abort_busy", bus.busy, 0);
    frame(-1, 0, dc, rd, up, wr, rs);
    chk("replay_done_cycle", dc, DONE_CYC);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      bus.start = $urandom_range(29) == 0;
      bus.stall = $urandom_range(4) == 0;
      if (rst) rst = 0;
      else if ($urandom_range(799) == 0) begin #2 rst = 1; end
    end
    @(negedge clk); bus.start = 0; bus.stall = 0; rst = 0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
